data_mem_lsu: RTL and testbench

Load/store initiator for the 32x8 data memory. The CPU control path hands it single load, single store, block fill or block copy requests over a valid/ready handshake. It drives the memory's address, write-data and write-enable inputs, captures the combinational read data, and returns a single-cycle response pulse. It sits between the CPU control/register file and the data memory, and is the only master on that memory.

---
 rtl/data_mem_pkg.sv | 36 +++
 rtl/data_mem_lsu_if.sv | 33 +++
 rtl/data_mem_lsu.sv | 126 ++++++++++++
 tb/tb_data_mem_lsu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared widths, op encodings, FSM states and the data memory reset image
// for the load/store unit and its 32x8 target memory.
package data_mem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_FILL  = 2'b10,
    OP_COPY  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_FILL,
    S_COPY_RD,
    S_COPY_WR,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] MEM_INIT_ADDR_A = 5'h1B;
  localparam logic [DATA_W-1:0] MEM_INIT_VAL_A  = 8'hFF;
  localparam logic [ADDR_W-1:0] MEM_INIT_ADDR_B = 5'h1C;
  localparam logic [DATA_W-1:0] MEM_INIT_VAL_B  = 8'hAA;

  function automatic logic [DATA_W-1:0] mem_init_val(input logic [ADDR_W-1:0] a);
    if (a == MEM_INIT_ADDR_A) return MEM_INIT_VAL_A;
    if (a == MEM_INIT_ADDR_B) return MEM_INIT_VAL_B;
    return '0;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response handshake plus the data memory port of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle pulse with no backpressure.
interface data_mem_lsu_if #(
  parameter int AW = data_mem_pkg::ADDR_W,
  parameter int DW = data_mem_pkg::DATA_W
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_src;
  logic [AW-1:0] req_len;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_en;
  logic [DW-1:0] mem_rdata;

  // Requester and memory side.
  modport master (
    output req_valid, req_op, req_addr, req_src, req_len, req_data, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, busy, mem_addr, mem_wdata, mem_en
  );

  // The load/store unit.
  modport slave (
    input  req_valid, req_op, req_addr, req_src, req_len, req_data, mem_rdata,
    output req_ready, rsp_valid, rsp_data, busy, mem_addr, mem_wdata, mem_en
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store initiator for the 32x8 data memory: single load/store, block fill
// and ascending byte-wise block copy, with a one-cycle completion pulse.
module data_mem_lsu
  import data_mem_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  data_mem_lsu_if.slave bus,
  output state_e state_o
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [DATA_W-1:0]   rsp_q, rsp_d;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_en;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      dst_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      buf_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      buf_q   <= buf_d;
      rsp_q   <= rsp_d;
    end
  end

  // Memory strobes depend only on registered state, so reset drops mem_en at once.
  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    buf_d     = buf_q;
    rsp_d     = rsp_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          dst_d  = bus.req_addr;
          src_d  = bus.req_src;
          cnt_d  = bus.req_len;
          data_d = bus.req_data;
          case (bus.req_op)
            OP_LOAD:  state_d = S_LOAD;
            OP_STORE: state_d = S_STORE;
            OP_FILL:  state_d = S_FILL;
            default:  state_d = S_COPY_RD;
          endcase
        end
      end
      S_LOAD: begin
        mem_addr = dst_q;
        rsp_d    = bus.mem_rdata;
        state_d  = S_DONE;
      end
      S_STORE: begin
        mem_addr  = dst_q;
        mem_wdata = data_q;
        mem_en    = 1'b1;
        rsp_d     = data_q;
        state_d   = S_DONE;
      end
      S_FILL: begin
        mem_addr  = dst_q;
        mem_wdata = data_q;
        mem_en    = 1'b1;
        dst_d     = dst_q + ADDR_W'(1);
        cnt_d     = cnt_q - ADDR_W'(1);
        if (cnt_q == '0) begin
          rsp_d   = data_q;
          state_d = S_DONE;
        end
      end
      S_COPY_RD: begin
        mem_addr = src_q;
        buf_d    = bus.mem_rdata;
        src_d    = src_q + ADDR_W'(1);
        state_d  = S_COPY_WR;
      end
      S_COPY_WR: begin
        mem_addr  = dst_q;
        mem_wdata = buf_q;
        mem_en    = 1'b1;
        dst_d     = dst_q + ADDR_W'(1);
        if (cnt_q == '0) begin
          rsp_d   = buf_q;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - ADDR_W'(1);
          state_d = S_COPY_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_data  = rsp_q;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_en    = mem_en;
  assign state_o       = state_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu driving a behavioural 32x8 data memory that
// starts from the reset image and is not cleared by the unit's reset.
module tb_data_mem_lsu;
  import data_mem_pkg::*;

  localparam int NV = 12;

  typedef struct {
    logic [1:0] op;
    logic [4:0] addr;
    logic [4:0] src;
    logic [4:0] len;
    logic [7:0] data;
    logic [7:0] exp_rsp;
    int         exp_lat;
    int         exp_wr;
  } vec_t;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     checks;
  int     failures;

  logic [7:0] mem [32];
  logic [7:0] exp_q [$];
  logic [4:0] tr_q [$];
  logic [4:0] trace_all [NV][$];
  vec_t       vecs [NV];

  data_mem_lsu_if bus ();

  data_mem_lsu dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on rising edge.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = mem_init_val(5'(i));
    forever begin
      @(posedge clk);
      if (bus.mem_en === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [4:0] addr, input logic [4:0] src,
                        input logic [4:0] len, input logic [7:0] data,
                        output int lat, output int wr_cnt);
    bit got;
    logic [7:0] exp;
    @(negedge clk);
    chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_src   = src;
    bus.req_len   = len;
    bus.req_data  = data;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom_range(0, 3));
    bus.req_addr  = 5'($urandom_range(0, 31));
    bus.req_src   = 5'($urandom_range(0, 31));
    bus.req_len   = 5'($urandom_range(0, 31));
    bus.req_data  = 8'($urandom_range(0, 255));
    tr_q.delete();
    lat    = 0;
    wr_cnt = 0;
    got    = 1'b0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        lat = k + 1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("rsp_data", 32'(bus.rsp_data), 32'(exp));
      end else begin
        tr_q.push_back(bus.mem_addr);
        if (bus.mem_en === 1'b1) wr_cnt++;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout actual=no_rsp required=rsp_valid");
    end
    @(negedge clk);
    chk("rsp_pulse_single", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int wr_cnt;
    int saw_rsp;
    checks   = 0;
    failures = 0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_src   = '0;
    bus.req_len   = '0;
    bus.req_data  = '0;

    vecs[0]  = '{OP_LOAD,  5'h1B, 5'h00, 5'd0, 8'h00, 8'hFF, 3, 0};
    vecs[1]  = '{OP_LOAD,  5'h1C, 5'h00, 5'd0, 8'h00, 8'hAA, 3, 0};
    vecs[2]  = '{OP_STORE, 5'h05, 5'h00, 5'd0, 8'h3C, 8'h3C, 3, 1};
    vecs[3]  = '{OP_LOAD,  5'h05, 5'h00, 5'd0, 8'h00, 8'h3C, 3, 0};
    vecs[4]  = '{OP_FILL,  5'h1E, 5'h00, 5'd3, 8'h77, 8'h77, 6, 4};
    vecs[5]  = '{OP_LOAD,  5'h02, 5'h00, 5'd0, 8'h00, 8'h00, 3, 0};
    vecs[6]  = '{OP_LOAD,  5'h01, 5'h00, 5'd0, 8'h00, 8'h77, 3, 0};
    vecs[7]  = '{OP_COPY,  5'h10, 5'h1B, 5'd1, 8'h00, 8'hAA, 6, 2};
    vecs[8]  = '{OP_LOAD,  5'h10, 5'h00, 5'd0, 8'h00, 8'hFF, 3, 0};
    vecs[9]  = '{OP_STORE, 5'h00, 5'h00, 5'd0, 8'h11, 8'h11, 3, 1};
    vecs[10] = '{OP_COPY,  5'h01, 5'h00, 5'd2, 8'h00, 8'h11, 8, 3};
    vecs[11] = '{OP_LOAD,  5'h03, 5'h00, 5'd0, 8'h00, 8'h11, 3, 0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(vecs[i].exp_rsp);
      do_req(vecs[i].op, vecs[i].addr, vecs[i].src, vecs[i].len, vecs[i].data, lat, wr_cnt);
      chk($sformatf("latency_v%0d", i),  32'(lat),    32'(vecs[i].exp_lat));
      chk($sformatf("write_cnt_v%0d", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
      trace_all[i] = tr_q;
    end

    chk("load_addr_trace",  32'(trace_all[0][0]), 32'h1B);
    chk("store_addr_trace", 32'(trace_all[2][0]), 32'h05);
    chk("copy_trace_len",   32'(trace_all[7].size()), 32'd4);
    if (trace_all[7].size() == 4) begin
      chk("copy_trace_0", 32'(trace_all[7][0]), 32'h1B);
      chk("copy_trace_1", 32'(trace_all[7][1]), 32'h10);
      chk("copy_trace_2", 32'(trace_all[7][2]), 32'h1C);
      chk("copy_trace_3", 32'(trace_all[7][3]), 32'h11);
    end
    chk("fill_mem_1e",   32'(mem[5'h1E]), 32'h77);
    chk("fill_mem_1f",   32'(mem[5'h1F]), 32'h77);
    chk("copy_mem_10",   32'(mem[5'h10]), 32'hFF);
    chk("copy_mem_11",   32'(mem[5'h11]), 32'hAA);
    chk("overlap_mem_1", 32'(mem[5'h01]), 32'h11);
    chk("overlap_mem_2", 32'(mem[5'h02]), 32'h11);
    chk("overlap_mem_3", 32'(mem[5'h03]), 32'h11);
    chk("overlap_mem_4", 32'(mem[5'h04]), 32'h00);

    // Reset in the middle of an 8-byte fill, just after the third write.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_FILL;
    bus.req_addr  = 5'h08;
    bus.req_len   = 5'd7;
    bus.req_data  = 8'h5A;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fill_busy_mid",   32'(bus.busy),   32'd1);
    chk("fill_mem_en_mid", 32'(bus.mem_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_en",    32'(bus.mem_en),    32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_busy",      32'(bus.busy),      32'd0);
    saw_rsp = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) saw_rsp++;
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) saw_rsp++;
    end
    chk("abort_no_rsp", 32'(saw_rsp), 32'd0);
    chk("abort_mem_08", 32'(mem[5'h08]), 32'h5A);
    chk("abort_mem_09", 32'(mem[5'h09]), 32'h5A);
    chk("abort_mem_0a", 32'(mem[5'h0A]), 32'h5A);
    chk("abort_mem_0b", 32'(mem[5'h0B]), 32'h00);

    exp_q.push_back(8'h5A);
    do_req(OP_LOAD, 5'h0A, 5'h00, 5'd0, 8'h00, lat, wr_cnt);
    chk("post_abort_load_lat", 32'(lat),    32'd3);
    chk("post_abort_load_wr",  32'(wr_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
